// File: rtl/tpu_pkg.sv
// ----------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the TPU weight path.
//   - default weight-memory address width, weight width and tile stride
//   - tile-count width and type
//   - weight fetcher FSM state encoding
// ----------------------------------------------------------------------------
package tpu_pkg;

   localparam int unsigned ADDR_W_DEF = 13;
   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned STRIDE_DEF = 4;
   localparam int unsigned TILE_CNT_W = 8;

   typedef logic [TILE_CNT_W-1:0] tile_cnt_t;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StHold  = 2'd2,
      StDone  = 2'd3
   } fetch_state_e;

endpackage : tpu_pkg

// File: rtl/weight_fetcher.sv
// ----------------------------------------------------------------------------
// weight_fetcher
// Walks a run of weight tiles in memory and presents each tile to the
// systolic array with a valid/ready handshake.
//
// Ports
//   clk               clock, all state on the rising edge
//   reset             asynchronous active-low reset
//   start             launch a fetch run (only looked at while idle)
//   base_addr         address of the first tile, captured on accepted start
//   num_tiles         number of tiles in the run, captured on accepted start
//   mem_addr          address to the weight memory (combinational read)
//   mem_w1..mem_w4    weights at mem_addr .. mem_addr+3
//   w_out1..w_out4    registered tile weights
//   w_valid           w_out1..4 hold a valid tile
//   w_ready           consumer takes the tile when w_valid && w_ready
//   busy              fetcher is not idle
//   done              one-cycle pulse after the final tile is taken
//   tile_idx          index of the tile currently fetched / held
// ----------------------------------------------------------------------------
module weight_fetcher
   import tpu_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned STRIDE = STRIDE_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [TILE_CNT_W-1:0] num_tiles,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [DATA_W-1:0]     mem_w1,
   input  logic [DATA_W-1:0]     mem_w2,
   input  logic [DATA_W-1:0]     mem_w3,
   input  logic [DATA_W-1:0]     mem_w4,
   output logic [DATA_W-1:0]     w_out1,
   output logic [DATA_W-1:0]     w_out2,
   output logic [DATA_W-1:0]     w_out3,
   output logic [DATA_W-1:0]     w_out4,
   output logic                  w_valid,
   input  logic                  w_ready,
   output logic                  busy,
   output logic                  done,
   output logic [TILE_CNT_W-1:0] tile_idx
);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   fetch_state_e            state_q, state_d;
   logic [ADDR_W-1:0]       base_q, base_d;
   tile_cnt_t               count_q, count_d;
   tile_cnt_t               idx_q, idx_d;
   logic [3:0][DATA_W-1:0]  w_q, w_d;

   logic [ADDR_W-1:0]       tile_offset;
   logic                    last_tile;

   // Address is derived from captured base and index only, so it cannot move
   // while a tile is held and it reads 0 straight out of reset.
   assign tile_offset = ADDR_W'(idx_q) * ADDR_W'(STRIDE);
   assign mem_addr    = base_q + tile_offset;

   // Only meaningful in HOLD, where count_q is known to be non-zero.
   assign last_tile   = (idx_q == (count_q - tile_cnt_t'(1)));

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      count_d = count_q;
      idx_d   = idx_q;
      w_d     = w_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               base_d  = base_addr;
               count_d = num_tiles;
               idx_d   = '0;
               state_d = (num_tiles != '0) ? StFetch : StDone;
            end
         end

         StFetch: begin
            w_d     = {mem_w4, mem_w3, mem_w2, mem_w1};
            state_d = StHold;
         end

         StHold: begin
            if (w_ready) begin
               if (last_tile) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + tile_cnt_t'(1);
                  state_d = StFetch;
               end
            end
         end

         StDone: begin
            // start is deliberately ignored here; a new run needs IDLE
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         base_q  <= '0;
         count_q <= '0;
         idx_q   <= '0;
         w_q     <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         w_q     <= w_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs, all decoded from registered state
   // -------------------------------------------------------------------------
   assign w_out1   = w_q[0];
   assign w_out2   = w_q[1];
   assign w_out3   = w_q[2];
   assign w_out4   = w_q[3];
   assign w_valid  = (state_q == StHold);
   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StDone);
   assign tile_idx = idx_q;

endmodule : weight_fetcher

// File: tb/tb_weight_fetcher.sv
// ----------------------------------------------------------------------------
// tb_weight_fetcher
// Self-checking bench for weight_fetcher. A word-addressed memory array feeds
// the DUT; expected tiles are computed directly as
// mem[(base + k*4 + j) mod 8192], and handshake timing follows the
// fetch-one-cycle / hold-until-ready / done-after-last-accept behaviour.
// ----------------------------------------------------------------------------
module tb_weight_fetcher;

   localparam int AW    = 13;
   localparam int DW    = 8;
   localparam int MSIZE = 1 << AW;

   logic          clk;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [7:0]    num_tiles;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_w1, mem_w2, mem_w3, mem_w4;
   logic [DW-1:0] w_out1, w_out2, w_out3, w_out4;
   logic          w_valid;
   logic          w_ready;
   logic          busy;
   logic          done;
   logic [7:0]    tile_idx;

   logic [DW-1:0] mem [MSIZE];
   logic [AW-1:0] a1, a2, a3;

   int n_checks = 0;
   int n_errors = 0;

   weight_fetcher dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .num_tiles (num_tiles),
      .mem_addr  (mem_addr),
      .mem_w1    (mem_w1),
      .mem_w2    (mem_w2),
      .mem_w3    (mem_w3),
      .mem_w4    (mem_w4),
      .w_out1    (w_out1),
      .w_out2    (w_out2),
      .w_out3    (w_out3),
      .w_out4    (w_out4),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .busy      (busy),
      .done      (done),
      .tile_idx  (tile_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // combinational read port
   assign a1     = mem_addr + 13'd1;
   assign a2     = mem_addr + 13'd2;
   assign a3     = mem_addr + 13'd3;
   assign mem_w1 = mem[mem_addr];
   assign mem_w2 = mem[a1];
   assign mem_w3 = mem[a2];
   assign mem_w4 = mem[a3];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int tile_addr(input int b, input int k);
      return (b + 4 * k) % MSIZE;
   endfunction

   function automatic logic [31:0] exp_word(input int b, input int k, input int j);
      return 32'(mem[(tile_addr(b, k) + j) % MSIZE]);
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_wout1"}, 32'(w_out1), 32'd0);
      check({tag, "_wout2"}, 32'(w_out2), 32'd0);
      check({tag, "_wout3"}, 32'(w_out3), 32'd0);
      check({tag, "_wout4"}, 32'(w_out4), 32'd0);
      check({tag, "_valid"}, 32'(w_valid), 32'd0);
      check({tag, "_busy"},  32'(busy),    32'd0);
      check({tag, "_done"},  32'(done),    32'd0);
      check({tag, "_idx"},   32'(tile_idx), 32'd0);
      check({tag, "_addr"},  32'(mem_addr), 32'd0);
   endtask

   // Runs one sequence from IDLE. Called at a negedge with the DUT idle.
   // stall < 0 means random stall per tile (0..3 cycles).
   // intrude: pulse start with other arguments during the first HOLD.
   // start_at_done: hold start high while DONE is shown; must not relaunch.
   task automatic run_seq(input int b, input int n, input int stall,
                          input bit intrude, input bit start_at_done);
      int st;
      start     = 1'b1;
      base_addr = AW'(b);
      num_tiles = 8'(n);
      w_ready   = 1'b0;
      @(negedge clk);
      start     = 1'b0;
      base_addr = AW'($urandom);
      num_tiles = 8'($urandom);
      for (int k = 0; k < n; k++) begin
         // fetch cycle
         check("fetch_valid", 32'(w_valid), 32'd0);
         check("fetch_busy",  32'(busy),    32'd1);
         check("fetch_done",  32'(done),    32'd0);
         check("fetch_addr",  32'(mem_addr), 32'(tile_addr(b, k)));
         check("fetch_idx",   32'(tile_idx), 32'(k));
         @(negedge clk);
         st = (stall < 0) ? $urandom_range(0, 3) : stall;
         for (int s = 0; s <= st; s++) begin
            check("hold_valid", 32'(w_valid), 32'd1);
            check("hold_done",  32'(done),    32'd0);
            check("hold_addr",  32'(mem_addr), 32'(tile_addr(b, k)));
            check("hold_idx",   32'(tile_idx), 32'(k));
            check("hold_w1",    32'(w_out1),  exp_word(b, k, 0));
            check("hold_w2",    32'(w_out2),  exp_word(b, k, 1));
            check("hold_w3",    32'(w_out3),  exp_word(b, k, 2));
            check("hold_w4",    32'(w_out4),  exp_word(b, k, 3));
            start = (intrude && k == 0 && s == 0);
            if (start) begin
               base_addr = AW'(100);
               num_tiles = 8'(7);
            end
            w_ready = (s == st);
            @(negedge clk);
            start   = 1'b0;
            w_ready = 1'b0;
         end
      end
      // done cycle
      check("done_pulse", 32'(done),    32'd1);
      check("done_valid", 32'(w_valid), 32'd0);
      check("done_busy",  32'(busy),    32'd1);
      start = start_at_done;
      @(negedge clk);
      start = 1'b0;
      check("after_done",      32'(done), 32'd0);
      check("after_done_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("idle_done",  32'(done),    32'd0);
      check("idle_valid", 32'(w_valid), 32'd0);
      check("idle_busy",  32'(busy),    32'd0);
   endtask

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      num_tiles = '0;
      w_ready   = 1'b0;
      for (int i = 0; i < MSIZE; i++) mem[i] = DW'(i);

      #3;
      check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("idle_busy0", 32'(busy), 32'd0);

      // two tiles from 0, ready always on after the fetch
      run_seq(0, 2, 0, 1'b0, 1'b0);
      // single tile at 8, consumer stalls 5 cycles
      run_seq(8, 1, 5, 1'b0, 1'b0);
      // empty run: done only
      run_seq(0, 0, 0, 1'b0, 1'b0);
      // address wrap
      run_seq(8188, 2, 0, 1'b0, 1'b0);
      run_seq(8190, 2, 1, 1'b0, 1'b0);
      // start during HOLD ignored
      run_seq(20, 2, 2, 1'b1, 1'b0);
      // start coinciding with done does not relaunch
      run_seq(40, 1, 0, 1'b0, 1'b1);

      // reset mid-run, in HOLD of tile 1 of 3
      start     = 1'b1;
      base_addr = AW'(16);
      num_tiles = 8'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      w_ready = 1'b1;
      @(negedge clk);
      w_ready = 1'b0;
      @(negedge clk);
      check("pre_reset_valid", 32'(w_valid), 32'd1);
      check("pre_reset_idx",   32'(tile_idx), 32'd1);
      #2 reset = 1'b0;
      #1 check_all_zero("async_reset");
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_reset_done", 32'(done), 32'd0);
         check("post_reset_busy", 32'(busy), 32'd0);
      end
      run_seq(200, 2, 0, 1'b0, 1'b0);

      // randomized runs over random memory contents
      for (int i = 0; i < MSIZE; i++) mem[i] = DW'($urandom);
      for (int r = 0; r < 25; r++) begin
         run_seq($urandom_range(0, MSIZE - 1), $urandom_range(0, 5), -1,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // hard time limit
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

endmodule : tb_weight_fetcher
